// File: rtl/keypad_pkg.sv
// Shared key codes, debouncer state encoding and key classification helpers
// for the keypad entry buffer.
package keypad_pkg;

  localparam logic [4:0] KEY_NONE    = 5'd16;
  localparam logic [4:0] KEY_INVALID = 5'd17;
  localparam logic [4:0] KEY_STAR    = 5'hE;
  localparam logic [4:0] KEY_HASH    = 5'hF;
  localparam logic [4:0] KEY_FUNC_A  = 5'hA;
  localparam logic [4:0] KEY_FUNC_B  = 5'hB;
  localparam logic [4:0] KEY_FUNC_C  = 5'hC;
  localparam logic [4:0] KEY_FUNC_D  = 5'hD;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_CHK = 3'd1,
    ST_ACCEPT    = 3'd2,
    ST_HELD      = 3'd3,
    ST_REL_CHK   = 3'd4
  } deb_state_e;

  // Invalid and any out-of-range code behave exactly like "no key".
  function automatic logic is_none(logic [4:0] code);
    return (code == KEY_NONE) || (code >= KEY_INVALID);
  endfunction

  function automatic logic is_func(logic [4:0] code);
    return (code == KEY_FUNC_A) || (code == KEY_FUNC_B) ||
           (code == KEY_FUNC_C) || (code == KEY_FUNC_D);
  endfunction

endpackage

// File: rtl/keypad_entry_buffer_if.sv
// Consumer-side bundle of the keypad entry buffer: committed number with
// valid/ack handshake, function-key event and error pulse.
interface keypad_entry_buffer_if #(
  parameter int N_DIG = 3
) ();

  logic [4*N_DIG-1:0] valor_bcd;
  logic               dato_valido;
  logic               dato_ack;
  logic               func_valid;
  logic [1:0]         func_code;
  logic               error;

  modport master (
    output valor_bcd, dato_valido, func_valid, func_code, error,
    input  dato_ack
  );

  modport slave (
    input  valor_bcd, dato_valido, func_valid, func_code, error,
    output dato_ack
  );

endinterface

// File: rtl/key_debouncer.sv
// Debounces the scanner key code and emits one key_event per physical press.
// state     | meaning
// IDLE      | no key; waiting for a non-none code
// PRESS_CHK | counting consecutive samples equal to the captured code
// ACCEPT    | one cycle: key_event asserted with key_code
// HELD      | key accepted and still down; never repeats
// REL_CHK   | counting consecutive none samples before re-arming
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEB_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] tecla,
  output logic       key_event,
  output logic [4:0] key_code
);

  // The sample that leaves IDLE/HELD already counts, so the timer holds the
  // number of further samples still needed minus one.
  localparam int         RELOAD_I = (DEB_CNT > 1) ? DEB_CNT - 2 : 0;
  localparam logic [3:0] RELOAD   = 4'(RELOAD_I);
  localparam logic       SINGLE   = (DEB_CNT <= 1);

  deb_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [4:0] cap, cap_nxt;
  logic       no_key;

  assign no_key = is_none(tecla);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cap   <= cap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_nxt   = cap;
    case (state)
      ST_IDLE: begin
        if (!no_key) begin
          cap_nxt   = tecla;
          cnt_nxt   = RELOAD;
          state_nxt = SINGLE ? ST_ACCEPT : ST_PRESS_CHK;
        end
      end
      ST_PRESS_CHK: begin
        if (tecla != cap)    state_nxt = ST_IDLE;
        else if (cnt == '0)  state_nxt = ST_ACCEPT;
        else                 cnt_nxt   = cnt - 4'd1;
      end
      ST_ACCEPT: state_nxt = ST_HELD;
      ST_HELD: begin
        if (no_key) begin
          cnt_nxt   = RELOAD;
          state_nxt = SINGLE ? ST_IDLE : ST_REL_CHK;
        end
      end
      ST_REL_CHK: begin
        if (!no_key)         state_nxt = ST_HELD;
        else if (cnt == '0)  state_nxt = ST_IDLE;
        else                 cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign key_event = (state == ST_ACCEPT);
  assign key_code  = cap;

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: debounced digit entry into a BCD edit buffer, commit
// via valid/ack handshake, function-key events. Build option KEYPAD_BACKSPACE_EN
// makes '*' delete the last digit instead of clearing the buffer.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int N_DIG   = 3,
  parameter int DEB_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           tecla,
  input  logic                 enter,
  output logic [1:0]           n_digitos,
  output logic [4*N_DIG-1:0]   buf_bcd,
  keypad_entry_buffer_if.master bus
);

  if (N_DIG < 1 || N_DIG > 3) begin : g_bad_ndig
    $error("keypad_entry_buffer: N_DIG must be 1..3");
  end

  localparam int         W     = 4 * N_DIG;
  localparam logic [1:0] N_MAX = 2'(N_DIG);

  logic         key_event;
  logic [4:0]   key_code;

  logic [W-1:0] buf_q, buf_n, valor_q, valor_n, dig_ext;
  logic [1:0]   n_q, n_n;
  logic         valido_q, valido_n;
  logic         fv_q, fv_n, err_q, err_n;
  logic [1:0]   fc_q, fc_n;
  logic         enter_q;
  logic [4:0]   fdiff;
  logic         is_digit, is_hash, is_star, is_fn;
  logic         commit_req, commit_ok;

  key_debouncer #(.DEB_CNT(DEB_CNT)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .tecla     (tecla),
    .key_event (key_event),
    .key_code  (key_code)
  );

  assign is_digit   = key_event && (key_code < 5'd10);
  assign is_hash    = key_event && (key_code == KEY_HASH);
  assign is_star    = key_event && (key_code == KEY_STAR);
  assign is_fn      = key_event && is_func(key_code);
  assign fdiff      = key_code - KEY_FUNC_A;
  // '#' and an enter edge in the same cycle collapse into one request.
  assign commit_req = is_hash || (enter && !enter_q);
  assign commit_ok  = commit_req && (n_q != 2'd0) && !valido_q;

  always_comb begin
    buf_n    = buf_q;
    n_n      = n_q;
    valor_n  = valor_q;
    valido_n = valido_q;
    fv_n     = is_fn;
    fc_n     = fc_q;
    err_n    = commit_req && !commit_ok;
    dig_ext  = '0;
    dig_ext[3:0] = key_code[3:0];

    if (valido_q && bus.dato_ack) valido_n = 1'b0;

    // Commit is applied first so a coincident digit lands in the fresh buffer.
    if (commit_ok) begin
      valor_n  = buf_q;
      valido_n = 1'b1;
      buf_n    = '0;
      n_n      = 2'd0;
    end

    if (is_digit) begin
      if (n_n < N_MAX) begin
        buf_n = (buf_n << 4) | dig_ext;
        n_n   = n_n + 2'd1;
      end else begin
        err_n = 1'b1;
      end
    end

    if (is_star) begin
`ifdef KEYPAD_BACKSPACE_EN
      if (n_n != 2'd0) begin
        buf_n = buf_n >> 4;
        n_n   = n_n - 2'd1;
      end
`else
      buf_n = '0;
      n_n   = 2'd0;
`endif
    end

    if (is_fn) fc_n = fdiff[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      n_q      <= '0;
      valor_q  <= '0;
      valido_q <= 1'b0;
      fv_q     <= 1'b0;
      fc_q     <= '0;
      err_q    <= 1'b0;
      enter_q  <= 1'b0;
    end else begin
      buf_q    <= buf_n;
      n_q      <= n_n;
      valor_q  <= valor_n;
      valido_q <= valido_n;
      fv_q     <= fv_n;
      fc_q     <= fc_n;
      err_q    <= err_n;
      enter_q  <= enter;
    end
  end

  assign buf_bcd         = buf_q;
  assign n_digitos       = n_q;
  assign bus.valor_bcd   = valor_q;
  assign bus.dato_valido = valido_q;
  assign bus.func_valid  = fv_q;
  assign bus.func_code   = fc_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer: digit entry, overflow, commit and
// handshake, bounce rejection, '*' handling, function keys and reset mid-press.
module tb_keypad_entry_buffer;
  localparam int N_DIG = 3;
  localparam int DEB   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       tecla;
  logic             enter;
  logic [1:0]       n_digitos;
  logic [4*N_DIG-1:0] buf_bcd;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int fv_seen  = 0;

  keypad_entry_buffer_if #(.N_DIG(N_DIG)) bus ();

  keypad_entry_buffer #(.N_DIG(N_DIG), .DEB_CNT(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tecla     (tecla),
    .enter     (enter),
    .n_digitos (n_digitos),
    .buf_bcd   (buf_bcd),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.error === 1'b1)      err_seen++;
    if (bus.func_valid === 1'b1) fv_seen++;
  endtask

  task automatic clr_mon();
    err_seen = 0;
    fv_seen  = 0;
  endtask

  task automatic press(input logic [4:0] code);
    tecla = code;
    repeat (DEB + 2) tick();
    tecla = 5'd16;
    repeat (DEB + 2) tick();
  endtask

  task automatic enter_edge();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic ack_pulse();
    bus.dato_ack = 1'b1;
    tick();
    bus.dato_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valor"},  32'(bus.valor_bcd),   32'h0);
    chk({tag, "_valido"}, 32'(bus.dato_valido), 32'h0);
    chk({tag, "_n"},      32'(n_digitos),       32'h0);
    chk({tag, "_buf"},    32'(buf_bcd),         32'h0);
    chk({tag, "_fv"},     32'(bus.func_valid),  32'h0);
    chk({tag, "_fc"},     32'(bus.func_code),   32'h0);
    chk({tag, "_err"},    32'(bus.error),       32'h0);
  endtask

  initial begin
    rst = 1'b1; tecla = 5'd16; enter = 1'b0; bus.dato_ack = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // First digit: action DEB+1 clocks after the first stable sample.
    tecla = 5'd4;
    repeat (DEB) tick();
    chk("lat_early_n", 32'(n_digitos), 32'd0);
    tick();
    chk("lat_act_n",   32'(n_digitos), 32'd1);
    chk("lat_act_buf", 32'(buf_bcd),   32'h4);
    tick();
    tecla = 5'd16;
    repeat (DEB + 2) tick();
    press(5'd2);
    press(5'd7);
    chk("t1_buf", 32'(buf_bcd),   32'h427);
    chk("t1_n",   32'(n_digitos), 32'd3);

    // Overflow, then commit with '#'.
    clr_mon();
    press(5'd9);
    chk("t2_ovf_err", 32'(err_seen), 32'd1);
    chk("t2_ovf_buf", 32'(buf_bcd),  32'h427);
    clr_mon();
    press(5'hF);
    chk("t2_commit_err",    32'(err_seen),        32'd0);
    chk("t2_commit_valor",  32'(bus.valor_bcd),   32'h427);
    chk("t2_commit_valido", 32'(bus.dato_valido), 32'd1);
    chk("t2_commit_n",      32'(n_digitos),       32'd0);
    chk("t2_commit_buf",    32'(buf_bcd),         32'h0);
    repeat (3) tick();
    chk("t2_hold_valido", 32'(bus.dato_valido), 32'd1);
    ack_pulse();
    chk("t2_ack_valido", 32'(bus.dato_valido), 32'd0);
    chk("t2_ack_valor",  32'(bus.valor_bcd),   32'h427);

    // Bounce 5,16,5,5 must not accept; long hold enters exactly one digit.
    tecla = 5'd5;  tick();
    tecla = 5'd16; tick();
    tecla = 5'd5;  tick();
    tick();
    chk("t3_bounce_n", 32'(n_digitos), 32'd0);
    repeat (48) tick();
    tecla = 5'd16;
    repeat (DEB + 2) tick();
    chk("t3_hold_n",   32'(n_digitos), 32'd1);
    chk("t3_hold_buf", 32'(buf_bcd),   32'h5);

    // One digit: '*' empties the buffer in either build.
    clr_mon();
    press(5'hE);
    chk("t4_star_n",   32'(n_digitos), 32'd0);
    chk("t4_star_err", 32'(err_seen),  32'd0);

    // Enter with empty buffer is rejected.
    clr_mon();
    enter_edge();
    chk("t4_empty_err",    32'(err_seen),        32'd1);
    chk("t4_empty_valido", 32'(bus.dato_valido), 32'd0);

    press(5'd3);
    press(5'd8);
    enter_edge();
    chk("t4_enter_valor",  32'(bus.valor_bcd),   32'h038);
    chk("t4_enter_valido", 32'(bus.dato_valido), 32'd1);
    chk("t4_enter_buf",    32'(buf_bcd),         32'h0);

    // Editing continues while the commit is pending; second commit rejected.
    press(5'd6);
    chk("t4_edit_buf", 32'(buf_bcd), 32'h6);
    clr_mon();
    press(5'hF);
    chk("t4_dbl_err",   32'(err_seen),      32'd1);
    chk("t4_dbl_valor", 32'(bus.valor_bcd), 32'h038);
    chk("t4_dbl_buf",   32'(buf_bcd),       32'h6);
    chk("t4_dbl_n",     32'(n_digitos),     32'd1);
    ack_pulse();
    chk("t4_ack_valido", 32'(bus.dato_valido), 32'd0);
    enter_edge();
    chk("t4_re_valor", 32'(bus.valor_bcd), 32'h6);
    ack_pulse();

    // '*' on 0x038.
    press(5'd3);
    press(5'd8);
    chk("t5_pre_buf", 32'(buf_bcd), 32'h038);
    clr_mon();
    press(5'hE);
`ifdef KEYPAD_BACKSPACE_EN
    chk("t5_bs_buf", 32'(buf_bcd),   32'h003);
    chk("t5_bs_n",   32'(n_digitos), 32'd1);
    press(5'hE);
`else
    chk("t5_clr_buf", 32'(buf_bcd),   32'h000);
    chk("t5_clr_n",   32'(n_digitos), 32'd0);
`endif
    press(5'hE);
    chk("t5_empty_err", 32'(err_seen),  32'd0);
    chk("t5_empty_n",   32'(n_digitos), 32'd0);
    chk("t5_empty_buf", 32'(buf_bcd),   32'h0);

    // '#' accepted in the same cycle as an enter edge: one commit, no error.
    press(5'd1);
    clr_mon();
    tecla = 5'hF;
    repeat (DEB) tick();
    enter = 1'b1;
    tick();
    chk("t5_both_valor",  32'(bus.valor_bcd),   32'h1);
    chk("t5_both_valido", 32'(bus.dato_valido), 32'd1);
    enter = 1'b0;
    tecla = 5'd16;
    repeat (DEB + 3) tick();
    chk("t5_both_err", 32'(err_seen), 32'd0);
    ack_pulse();

    // Function keys.
    clr_mon();
    press(5'hC);
    chk("t6_c_fv",   32'(fv_seen),       32'd1);
    chk("t6_c_code", 32'(bus.func_code), 32'd2);
    chk("t6_c_buf",  32'(buf_bcd),       32'h0);
    clr_mon();
    press(5'hD);
    chk("t6_d_fv",   32'(fv_seen),       32'd1);
    chk("t6_d_code", 32'(bus.func_code), 32'd3);
    clr_mon();
    press(5'hA);
    chk("t6_a_code", 32'(bus.func_code), 32'd0);

    // Reset in the middle of PRESS_CHK discards the press.
    press(5'd2);
    chk("t6_pre_buf", 32'(buf_bcd), 32'h2);
    tecla = 5'd4;
    repeat (2) tick();
    rst = 1'b1;
    tecla = 5'd16;
    tick();
    chk_all_zero("t6_rst");
    rst = 1'b0;
    clr_mon();
    repeat (DEB + 4) tick();
    chk("t6_post_n",   32'(n_digitos), 32'd0);
    chk("t6_post_buf", 32'(buf_bcd),   32'h0);
    chk("t6_post_ev",  32'(fv_seen + err_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
